// File: rtl/sar_adc_mc_if.sv
// Front-end and result bus of the multi-channel SAR controller.
// master = controller side, slave = analog front end / result consumer side.
interface sar_adc_mc_if #(
    parameter int ADC_WIDTH = 8,
    parameter int CH_W      = 2
);
    logic                 start;
    logic                 scan;
    logic [CH_W-1:0]      ch_sel;
    logic                 cmp;
    logic [ADC_WIDTH-1:0] DACF;
    logic [CH_W-1:0]      ch_mux;
    logic                 busy;
    logic                 eoc;
    logic                 eos;
    logic                 den;
    logic [ADC_WIDTH-1:0] Dout;
    logic [CH_W-1:0]      dout_ch;

    modport master (
        input  start, scan, ch_sel, cmp,
        output DACF, ch_mux, busy, eoc, eos, den, Dout, dout_ch
    );

    modport slave (
        output start, scan, ch_sel, cmp,
        input  DACF, ch_mux, busy, eoc, eos, den, Dout, dout_ch
    );
endinterface

// File: rtl/sar_adc_mc.sv
// Multi-channel SAR ADC controller: mux settling, per-bit DAC settling,
// single/scan sequencing and power-of-two oversampling with averaging.
module sar_adc_mc #(
    parameter int ADC_WIDTH  = 8,
    parameter int CH_NUM     = 4,
    parameter int CH_W       = 2,
    parameter int SETTLE_CYC = 1,
    parameter int MUX_CYC    = 2,
    parameter int AVG_LOG2   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    sar_adc_mc_if.master    adc
);
    localparam int ACC_W = ADC_WIDTH + AVG_LOG2;
    localparam int BIT_W = $clog2(ADC_WIDTH);
    localparam int REP_W = AVG_LOG2 + 1;
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(CH_NUM - 1);
    localparam logic [7:0]       MUX_LAST    = 8'(MUX_CYC - 1);
    localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYC);
    localparam logic [REP_W-1:0] REP_LAST    = REP_W'((1 << AVG_LOG2) - 1);
    localparam logic [BIT_W-1:0] BIT_MSB     = BIT_W'(ADC_WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_MUX, S_BIT, S_DONE} state_t;
    state_t r_state, w_state_next;

    logic                 r_start_q, r_scan, r_busy, r_eoc, r_eos, r_den;
    logic [CH_W-1:0]      r_ch_mux, r_dout_ch;
    logic [ADC_WIDTH-1:0] r_dout, r_code;
    logic [7:0]           r_cnt;
    logic [BIT_W-1:0]     r_bit;
    logic [ACC_W-1:0]     r_acc;
    logic [REP_W-1:0]     r_rep;

    logic                 w_start_e, w_mux_done, w_hold_done, w_lsb, w_last_rep, w_scan_more;
    logic [ADC_WIDTH-1:0] w_trial, w_resolved;
    logic [ACC_W-1:0]     w_avg;

    // busy gates the edge so the eoc cycle (IDLE, busy still high) ignores starts
    assign w_start_e   = adc.start & ~r_start_q & ~r_busy & (r_state == S_IDLE);
    assign w_mux_done  = (r_cnt == MUX_LAST);
    assign w_hold_done = (r_cnt == SETTLE_LAST);
    assign w_lsb       = (r_bit == '0);
    assign w_last_rep  = (r_rep == REP_LAST);
    assign w_scan_more = r_scan & (r_ch_mux != CH_LAST);
    assign w_avg       = r_acc >> AVG_LOG2;

    // Trial code: resolved upper bits, current bit forced high; midscale outside BIT.
    // Resolved code: current bit replaced by the comparator decision.
    for (genvar gi = 0; gi < ADC_WIDTH; gi++) begin : g_bits
        assign w_trial[gi] = (r_state == S_BIT)
                           ? (r_code[gi] | (r_bit == BIT_W'(gi)))
                           : ((gi == ADC_WIDTH - 1) ? 1'b1 : 1'b0);
        assign w_resolved[gi] = (r_bit == BIT_W'(gi)) ? adc.cmp : r_code[gi];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_start_e)  w_state_next = S_MUX;
            S_MUX:  if (w_mux_done) w_state_next = S_BIT;
            S_BIT:  if (w_hold_done && w_lsb && w_last_rep) w_state_next = S_DONE;
            S_DONE: w_state_next = w_scan_more ? S_MUX : S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_start_q <= 1'b0;
            r_scan    <= 1'b0;
            r_busy    <= 1'b0;
            r_eoc     <= 1'b0;
            r_eos     <= 1'b0;
            r_den     <= 1'b0;
            r_ch_mux  <= '0;
            r_dout_ch <= '0;
            r_dout    <= '0;
            r_code    <= '0;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_acc     <= '0;
            r_rep     <= '0;
        end else begin
            r_start_q <= adc.start;
            r_eoc     <= 1'b0;
            r_eos     <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_busy <= w_start_e;
                    if (w_start_e) begin
                        r_scan   <= adc.scan;
                        r_ch_mux <= adc.scan ? '0 : adc.ch_sel;
                        r_den    <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                S_MUX: begin
                    if (w_mux_done) begin
                        r_cnt  <= '0;
                        r_bit  <= BIT_MSB;
                        r_code <= '0;
                        r_acc  <= '0;
                        r_rep  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_BIT: begin
                    if (w_hold_done) begin
                        r_cnt <= '0;
                        if (w_lsb) begin
                            // repeat restarts from midscale without a new mux wait
                            r_acc  <= r_acc + ACC_W'(w_resolved);
                            r_rep  <= r_rep + 1'b1;
                            r_code <= '0;
                            r_bit  <= BIT_MSB;
                        end else begin
                            r_code <= w_resolved;
                            r_bit  <= r_bit - 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_eoc     <= 1'b1;
                    r_den     <= 1'b1;
                    r_dout    <= w_avg[ADC_WIDTH-1:0];
                    r_dout_ch <= r_ch_mux;
                    r_eos     <= ~r_scan | (r_ch_mux == CH_LAST);
                    if (w_scan_more) begin
                        r_ch_mux <= r_ch_mux + 1'b1;
                        r_cnt    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign adc.DACF    = w_trial;
    assign adc.ch_mux  = r_ch_mux;
    assign adc.busy    = r_busy;
    assign adc.eoc     = r_eoc;
    assign adc.eos     = r_eos;
    assign adc.den     = r_den;
    assign adc.Dout    = r_dout;
    assign adc.dout_ch = r_dout_ch;
endmodule

// File: doc/sar_adc_mc.md
Name: sar_adc_mc

Overview:
Multi-channel successive-approximation ADC digital controller. It drives an external analog input mux, a DAC and a comparator, and is written as pure logic so it ports to any FPGA.
Generalised successor to the single-channel SAR controller, adding:
- parametrised DAC settling time and mux settling time;
- single-channel or scan mode;
- power-of-two oversampling with averaging.
It sits between the analog front end and the system-side result consumer.

Parameters:
ADC_WIDTH, 8, result/DAC width in bits (2..16)
CH_NUM, 4, number of analog channels (1..16)
CH_W, 2, channel index width, ceil(log2(CH_NUM)) and at least 1
SETTLE_CYC, 1, extra cycles the DAC is held before cmp is sampled for each bit (0..15)
MUX_CYC, 2, cycles waited after switching ch_mux before the first trial (1..255)
AVG_LOG2, 0, conversions per channel = 2^AVG_LOG2; result averaged (0..4)

Ports:
clk  in  1  clock; single clock domain
rst_n  in  1  synchronous, active-low reset
start  in  1  conversion request; rising edge triggers
scan  in  1  sampled at the start edge: 0 = convert ch_sel only, 1 = convert channels 0..CH_NUM-1
ch_sel  in  CH_W  channel for single mode; sampled at the start edge
cmp  in  1  comparator output; 1 means analog input >= DAC voltage
DACF  out  ADC_WIDTH  DAC trial code
ch_mux  out  CH_W  analog mux select
busy  out  1  high from the start edge until the last eoc, inclusive
eoc  out  1  one-cycle pulse per completed channel result
eos  out  1  one-cycle pulse coincident with the final eoc of a sequence (single mode: every eoc)
den  out  1  result valid; set with eoc, cleared at the next accepted start edge
Dout  out  ADC_WIDTH  averaged result
dout_ch  out  CH_W  channel of Dout

Behaviour:
- Reset (rst_n=0 at a clk edge): all state returns to IDLE and the start edge register clears. Output values after reset:
  - DACF = 1 followed by zeros (midscale);
  - ch_mux = 0, busy = 0, eoc = 0, eos = 0, den = 0, Dout = 0, dout_ch = 0.
  - A reset mid-conversion abandons the conversion; no eoc is produced.
- Start detection: start_e = start & ~start_q, where start_q is start registered. start_e is acted on only in IDLE; edges while busy are ignored, not queued. A level held high does not retrigger.
- States:
  - IDLE: DACF = midscale. On start_e: latch scan; ch_mux <= (scan ? 0 : ch_sel); clear den; busy <= 1; go to MUX.
  - MUX: hold for MUX_CYC cycles; clear the accumulator and repeat counter; go to BIT.
  - BIT: bit i runs MSB to LSB.
    - Entering bit i: DACF = resolved upper bits, bit i = 1, lower bits 0.
    - Hold bit i for SETTLE_CYC+1 cycles.
    - On the last cycle, cmp is registered into bit i.
    - After the LSB: add the code to an (ADC_WIDTH+AVG_LOG2)-bit accumulator and increment the repeat counter.
    - If repeats remain, restart BIT from midscale with no mux wait; otherwise go to DONE.
  - DONE (1 cycle): the following happen in this cycle:
    - eoc = 1, den = 1;
    - Dout = accumulator >> AVG_LOG2 (truncation);
    - dout_ch = ch_mux;
    - eos = 1 if single mode or ch_mux = CH_NUM-1.
    - Next state: if scan and ch_mux < CH_NUM-1, ch_mux increments and the state goes to MUX. Otherwise busy <= 0 on the next edge and the state goes to IDLE.
- Latency: T = MUX_CYC + 2^AVG_LOG2 * ADC_WIDTH * (SETTLE_CYC+1).
  - eoc is high in the cycle starting 1+T edges after the edge that sampled start_e.
  - In scan mode, consecutive eoc pulses are 1+T cycles apart.
  - With defaults, T = 18 and eoc occurs 19 cycles after start.
- Consecutive conversions: a start edge arriving the cycle after busy falls is accepted.
- Dout and dout_ch hold until the next DONE. den stays high until the next accepted start.
- Boundary codes: all-zero and full-scale inputs must resolve exactly. No overflow is possible: the accumulator is sized for 2^AVG_LOG2 * (2^ADC_WIDTH - 1).
- CH_NUM = 1: scan behaves as single mode on channel 0.

Test Plan:
- Single conversion with defaults; comparator model cmp = (vin >= DACF), vin = 0xA5, ch_sel = 2, start edge at edge 0 -> eoc/eos/den at edge 19; Dout = 0xA5, dout_ch = 2; busy falls at edge 20; DACF sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5.
- Scan with channel inputs 0x00, 0xFF, 0x5A, 0x01 -> eoc at edges 19, 38, 57, 76 with Dout 0x00, 0xFF, 0x5A, 0x01 and dout_ch 0..3; eos only at edge 76; ch_mux steps 0 to 3.
- AVG_LOG2 = 2, vin per repeat 0x40, 0x41, 0x41, 0x42 -> sum 0x104, Dout = 0x41; eoc at edge 1 + 2 + 64 = 67.
- Start edge at edge 5 while busy, and start held high through the whole conversion -> exactly one eoc (edge 19), no second conversion; a new edge at edge 21 gives eoc at edge 40.
- rst_n = 0 at edge 10 mid-conversion -> at edge 10 all outputs equal their reset values and no eoc is produced; a start edge after release converts normally.
- SETTLE_CYC = 0, MUX_CYC = 1, vin = 0x7F -> eoc at edge 10, Dout = 0x7F; cmp is only sampled at bit-resolve cycles (toggling cmp in hold cycles with SETTLE_CYC = 3 has no effect).
